// File: rtl/fc_result_reader.sv
// fc_result_reader: captures a parallel FC result vector and streams it out.
// Optional argmax (predicted class) when FC_RESULT_READER_ARGMAX_EN is defined.
module fc_result_reader #(
  parameter  int WIDTH = 8,
  parameter  int IN    = 84,
  parameter  int OUT   = 10,
  localparam int ZW    = WIDTH*2 + $clog2(IN),
  localparam int IW    = $clog2(OUT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [ZW-1:0] z [0:OUT-1],
  output logic          out_valid,
  input  logic          out_ready,
  output logic [ZW-1:0] out_data,
  output logic [IW-1:0] out_idx,
  output logic          out_last,
  output logic          cls_valid,
  output logic [IW-1:0] cls_idx
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_RESULT
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [ZW-1:0] buf_q [0:OUT-1];
  logic [IW-1:0] idx_q;
  logic          cap;
  logic          hs;
  logic          last;

  assign cap  = (state_q == S_IDLE) && in_valid;
  assign hs   = (state_q == S_STREAM) && out_ready;
  assign last = (idx_q == IW'(OUT-1));

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_STREAM);
  assign out_data  = buf_q[idx_q];
  assign out_idx   = idx_q;
  assign out_last  = out_valid && last;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (in_valid) state_d = S_STREAM;
      S_STREAM: if (out_ready && last)
`ifdef FC_RESULT_READER_ARGMAX_EN
                  state_d = S_RESULT;
`else
                  state_d = S_IDLE;
`endif
      S_RESULT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Frame buffer, written only at capture so z may change freely
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < OUT; i++) buf_q[i] <= '0;
    end else if (cap) begin
      for (int i = 0; i < OUT; i++) buf_q[i] <= z[i];
    end
  end

  // Beat index, advances on each accepted beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      idx_q <= '0;
    else if (cap) idx_q <= '0;
    else if (hs)  idx_q <= last ? '0 : idx_q + 1'b1;
  end

`ifdef FC_RESULT_READER_ARGMAX_EN
  logic [ZW-1:0] best_val_q;
  logic [IW-1:0] best_idx_q;
  logic [IW-1:0] cls_q;
  logic          gt;
  logic [IW-1:0] win_idx;

  // Strict compare keeps the lowest index on ties
  assign gt      = (buf_q[idx_q] > best_val_q);
  assign win_idx = gt ? idx_q : best_idx_q;

  // Running argmax; result latched at the last beat so it holds
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      best_val_q <= '0;
      best_idx_q <= '0;
      cls_q      <= '0;
    end else if (cap) begin
      best_val_q <= '0;
      best_idx_q <= '0;
    end else if (hs) begin
      if (gt) begin
        best_val_q <= buf_q[idx_q];
        best_idx_q <= idx_q;
      end
      if (last) cls_q <= win_idx;
    end
  end

  assign cls_valid = (state_q == S_RESULT);
  assign cls_idx   = cls_q;
`else
  assign cls_valid = 1'b0;
  assign cls_idx   = '0;
`endif

endmodule

// File: doc/fc_result_reader.md
# fc_result_reader

Sequential consumer for the fully-connected layer outputs (e.g. `fc84_10`). On a handshake it captures the parallel `z[0:OUT-1]` vector into an internal buffer. It then streams the elements out one per beat over a valid/ready interface. Optionally it computes the argmax (predicted class) while streaming. It sits between the combinational FC stage and downstream logic that consumes serial data.

## Interface
- `WIDTH`, default 8: operand width of the FC layer.
- `IN`, default 84: FC input count; sets the result width.
- `OUT`, default 10: FC output count = number of beats per frame.
- Derived (localparam): `ZW = WIDTH*2+$clog2(IN)`; `IW = $clog2(OUT)`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `in_valid` in 1: `z` holds a complete result vector.
- `in_ready` out 1: block can capture a vector.
- `z[0:OUT-1]` in ZW each: parallel FC results, unsigned.
- `out_valid` out 1: `out_data` is valid.
- `out_ready` in 1: downstream accepts the beat.
- `out_data` out ZW: current element `buf[idx]`.
- `out_idx` out IW: index of the current element.
- `out_last` out 1: current beat is element `OUT-1`.
- `cls_valid` out 1: one-cycle pulse; `cls_idx` is valid.
- `cls_idx` out IW: argmax of the last frame.

## Operation
- The FSM has three states: IDLE, STREAM, RESULT.
- IDLE:
  - `in_ready=1`.
  - On `in_valid`, latch all `z` into `buf`, set `idx=0`, `best_val=0`, `best_idx=0`, and go to STREAM.
- STREAM:
  - `out_valid=1`, `out_data=buf[idx]`, `out_idx=idx`, `out_last=(idx==OUT-1)`.
  - On `out_valid&&out_ready`, if `buf[idx] > best_val` (unsigned, strict), update `best_val` and `best_idx`.
  - At that same handshake, if `idx==OUT-1`, go to RESULT. Otherwise increment `idx`.
- RESULT:
  - `cls_valid=1` and `cls_idx` = final argmax, including the last beat's comparison.
  - Go to IDLE unconditionally.
- Ties resolve to the lowest index. An all-zero frame gives `cls_idx=0`.
- `in_valid` is ignored outside IDLE. `buf` is not modified, so a changing `z` never corrupts a frame in progress.
- The buffer is captured once per frame; `out_data` is always read from `buf`, never from `z`.
- `cls_idx` holds its value until the next RESULT.

## Timing
- Reset values:
  - State = IDLE, so `in_ready=1`.
  - `out_valid=0`, `out_last=0`, `cls_valid=0`.
  - `out_data=0`, `out_idx=0`, `cls_idx=0`.
  - `buf` cleared.
- Capture: `out_valid` rises in the cycle after the `in_valid&&in_ready` edge.
- Throughput: one beat per cycle while `out_ready=1`, so a frame takes OUT cycles without backpressure.
- Backpressure: while `out_valid&&!out_ready`, `out_data`, `out_idx` and `out_last` stay stable.
- `cls_valid` asserts in the cycle after the last beat's handshake. `in_ready` returns the cycle after that.
- Frame-to-frame gap with argmax compiled in:
  - Capture, then OUT beats, then 1 RESULT cycle, then IDLE.
  - Minimum frame period is OUT+2 cycles.
- `rst` mid-frame:
  - Asynchronous return to IDLE; all outputs go to reset values immediately.
  - The partial frame is discarded and no `cls_valid` is generated.
- `in_valid` and `out_ready` are both sampled on the same edge. They never interact, because `in_ready` and `out_valid` are never high together.

## Configuration
- Macro `FC_RESULT_READER_ARGMAX_EN`.
- Defined:
  - Argmax comparator and RESULT state are present.
  - `cls_valid` and `cls_idx` behave as above.
- Undefined:
  - No comparator or `best_*` registers.
  - The last handshake goes STREAM to IDLE directly, so `in_ready=1` the next cycle and the minimum frame period is OUT+1.
  - `cls_valid` is tied 0 and `cls_idx` is tied 0.
  - Streaming behaviour is otherwise identical.

## Test plan
- **Basic frame:** `z[k]=k*0x100` (k=0..9), `in_valid` for one cycle, `out_ready=1`. Required:
  - 10 consecutive beats with `out_data` 0x0,0x100,…,0x900 and `out_idx` 0..9.
  - `out_last` on beat 9.
  - `cls_valid` one cycle later with `cls_idx=9`.
- **Backpressure and mid-frame input:** same frame; hold `out_ready=0` for 3 cycles at `idx=4`, and drive a new `z`/`in_valid` during the stall. Required:
  - `out_data=0x400` and `out_idx=4` stable throughout the stall.
  - `in_ready=0` throughout; the stream resumes with 0x500, unchanged.
- **Ties:** all `z=0x5`, and separately all `z=0`. Required: `cls_idx=0` for both.
- **Max not at ends:** `z[3]=0x1FFFF`, others 0x10, and `z[7]=0x1FFFF` in a second frame together with the first. Required: `cls_idx=3` (lowest index wins the tie).
- **Reset mid-frame:** assert `rst` at beat 5 for one cycle. Required:
  - Immediate `out_valid=0`, `in_ready=1`, no `cls_valid`.
  - The next frame streams correctly from `idx=0`.
- **Back-to-back frames:** hold `in_valid=1` continuously with alternating vectors. Required:
  - Captures exactly every 12 cycles.
  - Every beat matches the captured vector.
  - With the macro undefined, every 11 cycles and `cls_valid` stays 0.
